distance_uart_tx: RTL and testbench
===================================

Name: distance_uart_tx

Overview:
- Downstream consumer of the ultrasonic distance stage.
- Accepts one 11-bit centimetre reading per valid/ready handshake and converts it to 4 ASCII decimal digits.
- Serialises the line "dddd\r\n" on a UART TX pin (8N1) for the radar display host.
- A timeout/error flag sent with the reading replaces the digits with "----".

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- BAUD_DIV, CLK_HZ/BAUD (integer truncation, 234 at defaults), clock cycles per UART bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- dist_cm  input  11  distance in cm, 0..2047.
- dist_err  input  1  reading invalid (echo timeout); sampled with dist_cm.
- dist_valid  input  1  upstream offers a reading.
- dist_ready  output  1  block can accept a reading.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high from acceptance until the last stop bit completes.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - tx=1, dist_ready=1, busy=0.
  - FSM to IDLE; all counters and shift registers to 0.
  - Applies mid-frame too: tx returns high on that edge and the partial frame is abandoned.
- Handshake:
  - dist_ready=1 only in IDLE.
  - Transfer occurs on a clk edge with dist_valid=1 and dist_ready=1; dist_cm and dist_err are latched on that edge.
  - dist_ready drops and busy rises on the same edge.
  - dist_valid while not ready is ignored. There is no buffering and no back-to-back queue.
- FSM states: IDLE -> CONVERT -> SEND_START -> SEND_DATA -> SEND_STOP -> (next char or IDLE).
- CONVERT:
  - Iterative double-dabble: 11 cycles, one bit per cycle, into 4 BCD digits (thousands..units).
  - Add-3 to any nibble >=5 before each shift.
  - CONVERT lasts exactly 11 cycles even if dist_err=1; the result is then discarded.
- Character sequence:
  - dist_err=0: '0'+thousands, '0'+hundreds, '0'+tens, '0'+units, 0x0D, 0x0A. Leading zeros are kept, e.g. 57 -> "0057\r\n".
  - dist_err=1: 0x2D x4, 0x0D, 0x0A.
- Timing:
  - Acceptance edge = cycle 0.
  - tx drives the first start bit (0) from the edge at cycle 12.
- Frame:
  - Start bit 0, then 8 data bits LSB first, then 1 stop bit 1.
  - Each bit holds for exactly BAUD_DIV cycles, counted by a bit-period counter that reloads at every bit boundary.
  - The next character's start bit immediately follows the previous stop bit; there is no extra idle.
- Completion:
  - Whole message = 60 bit periods = 60*BAUD_DIV cycles after cycle 12.
  - On the edge ending the final stop bit: FSM to IDLE, dist_ready=1, busy=0.
  - A new reading may be accepted on that same edge's following cycle.
- Character index: a 3-bit counter 0..5; after index 5 completes it wraps to 0 and returns to IDLE.
- Input stability: dist_cm and dist_err changes after acceptance have no effect on the message in flight.

Test Plan:
- Params CLK_HZ=1000000, BAUD=100000 (BAUD_DIV=10), applied to every scenario below.
- Reset:
  - Stimulus: rst_n low for 3 cycles, then high, no valid.
  - Required: tx=1, dist_ready=1, busy=0 for 100 cycles.
- Single reading:
  - Stimulus: dist_cm=57, dist_err=0, valid for 1 cycle.
  - Required: tx falls at cycle 12; decoded bytes 0x30,0x30,0x35,0x37,0x0D,0x0A.
  - Required: dist_ready returns at cycle 612.
- Maximum value:
  - Stimulus: dist_cm=2047.
  - Required: decoded bytes "2047\r\n".
  - Stimulus: dist_cm=0.
  - Required: decoded bytes "0000\r\n".
- Error flag:
  - Stimulus: dist_cm=1234, dist_err=1.
  - Required: decoded bytes "----\r\n"; same 612-cycle completion.
- Busy drop:
  - Stimulus: second valid with dist_cm=999 during message 1 (dist_cm=100).
  - Required: only "0100\r\n" is sent; the 999 reading is never transmitted.
  - Stimulus: valid held high continuously.
  - Required: the next message's start bit at 13 cycles after dist_ready re-asserts.
- Reset mid-operation:
  - Stimulus: rst_n=0 during the 3rd character's data bits.
  - Required: tx=1 on that edge and stays 1; dist_ready=1.
  - Stimulus: new reading 42 after reset.
  - Required: clean "0042\r\n".

Source files
------------

// File: rtl/distance_uart_tx.sv
// Converts an 11-bit centimetre reading to four ASCII digits and sends "dddd\r\n"
// (or "----\r\n" on error) as 8N1 UART frames.
module distance_uart_tx #(
    parameter int unsigned CLK_HZ   = 27000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] dist_cm,
    input  logic        dist_err,
    input  logic        dist_valid,
    output logic        dist_ready,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CW = $clog2(BAUD_DIV + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_CONVERT    = 3'd1;
    localparam logic [2:0] S_SEND_START = 3'd2;
    localparam logic [2:0] S_SEND_DATA  = 3'd3;
    localparam logic [2:0] S_SEND_STOP  = 3'd4;

    logic [2:0]    state_q,    state_d;
    logic [10:0]   bin_q,      bin_d;
    logic [15:0]   bcd_q,      bcd_d;
    logic          err_q,      err_d;
    logic [3:0]    conv_cnt_q, conv_cnt_d;
    logic [CW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [2:0]    chr_idx_q,  chr_idx_d;
    logic [7:0]    shreg_q,    shreg_d;
    logic          tx_q,       tx_d;

    logic [15:0]   bcd_adj;
    logic [7:0]    char_cur;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        char_cur = 8'h0A;
        case (chr_idx_q)
            3'd0:    char_cur = err_q ? 8'h2D : {4'h3, bcd_q[15:12]};
            3'd1:    char_cur = err_q ? 8'h2D : {4'h3, bcd_q[11:8]};
            3'd2:    char_cur = err_q ? 8'h2D : {4'h3, bcd_q[7:4]};
            3'd3:    char_cur = err_q ? 8'h2D : {4'h3, bcd_q[3:0]};
            3'd4:    char_cur = 8'h0D;
            default: char_cur = 8'h0A;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        err_d      = err_q;
        conv_cnt_d = conv_cnt_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        chr_idx_d  = chr_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;

        case (state_q)
            S_IDLE: begin
                if (dist_valid) begin
                    bin_d      = dist_cm;
                    err_d      = dist_err;
                    bcd_d      = '0;
                    conv_cnt_d = '0;
                    state_d    = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d      = {bcd_adj[14:0], bin_q[10]};
                bin_d      = {bin_q[9:0], 1'b0};
                conv_cnt_d = conv_cnt_q + 4'd1;
                if (conv_cnt_q == 4'd10) begin
                    // One extra count: the first start bit begins a cycle after the last shift.
                    state_d    = S_SEND_START;
                    chr_idx_d  = '0;
                    baud_cnt_d = CW'(BAUD_DIV);
                end
            end
            S_SEND_START: begin
                if (baud_cnt_q == '0) begin
                    state_d    = S_SEND_DATA;
                    tx_d       = char_cur[0];
                    shreg_d    = {1'b0, char_cur[7:1]};
                    bit_cnt_d  = '0;
                    baud_cnt_d = CW'(BAUD_DIV - 1);
                end else begin
                    tx_d       = 1'b0;
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            S_SEND_DATA: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = CW'(BAUD_DIV - 1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_SEND_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            S_SEND_STOP: begin
                if (baud_cnt_q == '0) begin
                    if (chr_idx_q == 3'd5) begin
                        state_d   = S_IDLE;
                        chr_idx_d = '0;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        state_d    = S_SEND_START;
                        chr_idx_d  = chr_idx_q + 3'd1;
                        tx_d       = 1'b0;
                        baud_cnt_d = CW'(BAUD_DIV - 1);
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            err_q      <= 1'b0;
            conv_cnt_q <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            chr_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            err_q      <= err_d;
            conv_cnt_q <= conv_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            chr_idx_q  <= chr_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign dist_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_distance_uart_tx.sv
// Bench for distance_uart_tx: decodes the UART line and compares against messages
// built directly from the decimal value of each reading.
module tb_distance_uart_tx;

    localparam int BD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dist_cm = '0;
    logic        dist_err = 1'b0;
    logic        dist_valid = 1'b0;
    logic        dist_ready;
    logic        tx;
    logic        busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    distance_uart_tx #(
        .CLK_HZ(1000000),
        .BAUD  (100000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dist_cm   (dist_cm),
        .dist_err  (dist_err),
        .dist_valid(dist_valid),
        .dist_ready(dist_ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_char(input int d, input bit e, input int i);
        int digit;
        if (i == 4) return 8'h0D;
        if (i == 5) return 8'h0A;
        if (e) return 8'h2D;
        case (i)
            0:       digit = d / 1000;
            1:       digit = (d / 100) % 10;
            2:       digit = (d / 10) % 10;
            default: digit = d % 10;
        endcase
        return 8'(48 + digit);
    endfunction

    task automatic send(input int d, input bit e, output int acc);
        @(negedge clk);
        dist_cm    = 11'(d);
        dist_err   = e;
        dist_valid = 1'b1;
        @(posedge clk);
        #1;
        acc        = cyc;
        dist_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dist_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept: ready=%b busy=%b, required ready=0 busy=1", dist_ready, busy);
        end
    endtask

    // Called at the negedge after the acceptance edge; decodes six frames.
    task automatic recv(input int acc, input int d, input bit e);
        int fall;
        int prev_fall;
        int n;
        logic [7:0] got;
        prev_fall = 0;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (tx !== 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (tx !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL start_timeout: char %0d of %0d, tx stayed %b", i, d, tx);
                return;
            end
            fall = cyc;
            checks++;
            if (i == 0) begin
                if (fall - acc !== 12) begin
                    errors++;
                    $display("FAIL start_latency: got %0d cycles, required 12", fall - acc);
                end
            end else if (fall - prev_fall !== 10 * BD) begin
                errors++;
                $display("FAIL char_gap: char %0d gap %0d, required %0d", i, fall - prev_fall, 10 * BD);
            end
            repeat (BD / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (BD) @(negedge clk);
                got[b] = tx;
            end
            checks++;
            if (got !== exp_char(d, e, i)) begin
                errors++;
                $display("FAIL char: reading %0d err %0b idx %0d got 0x%02h, required 0x%02h",
                         d, e, i, got, exp_char(d, e, i));
            end
            repeat (BD) @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL stop_bit: idx %0d got %b, required 1", i, tx);
            end
            prev_fall = fall;
        end
        repeat (acc + 611 - cyc) @(negedge clk);
        checks++;
        if (dist_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_early: cycle %0d ready=%b busy=%b, required 0/1", cyc - acc, dist_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (dist_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL done: cycle %0d ready=%b busy=%b tx=%b, required 1/0/1",
                     cyc - acc, dist_ready, busy, tx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || dist_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d tx=%b ready=%b busy=%b, required 1/1/0",
                         i, tx, dist_ready, busy);
            end
        end
    endtask

    task automatic test_single();
        int acc;
        send(57, 1'b0, acc);
        recv(acc, 57, 1'b0);
    endtask

    task automatic test_limits();
        int acc;
        send(2047, 1'b0, acc);
        recv(acc, 2047, 1'b0);
        send(0, 1'b0, acc);
        recv(acc, 0, 1'b0);
    endtask

    task automatic test_error();
        int acc;
        send(1234, 1'b1, acc);
        recv(acc, 1234, 1'b1);
    endtask

    task automatic test_random();
        int acc;
        int d;
        bit e;
        for (int k = 0; k < 4; k++) begin
            d = int'($urandom_range(0, 2047));
            e = ($urandom_range(0, 3) == 0);
            send(d, e, acc);
            recv(acc, d, e);
        end
    endtask

    task automatic test_busy_drop();
        int acc;
        int lows;
        send(100, 1'b0, acc);
        fork
            recv(acc, 100, 1'b0);
            begin
                repeat (40) @(negedge clk);
                dist_cm    = 11'd999;
                dist_err   = 1'b1;
                dist_valid = 1'b1;
                repeat (300) @(negedge clk);
                dist_valid = 1'b0;
                dist_err   = 1'b0;
            end
        join
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++;
        if (lows !== 0) begin
            errors++;
            $display("FAIL dropped_reading: %0d non-idle cycles after message, required 0", lows);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int acc2;
        @(negedge clk);
        dist_cm    = 11'd321;
        dist_err   = 1'b0;
        dist_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        recv(acc, 321, 1'b0);
        dist_cm = 11'd654;
        @(posedge clk);
        #1;
        acc2       = cyc;
        dist_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_valid_accept: busy=%b one cycle after ready, required 1", busy);
        end
        recv(acc2, 654, 1'b0);
    endtask

    task automatic test_reset_mid();
        int acc;
        int bad;
        send(1500, 1'b0, acc);
        repeat (acc + 224 - cyc) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_bit: third char bit0 tx=%b, required 0", tx);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || dist_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: tx=%b ready=%b busy=%b, required 1/1/0", tx, dist_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || dist_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: %0d non-idle cycles, required 0", bad);
        end
        send(42, 1'b0, acc);
        recv(acc, 42, 1'b0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_limits();
        test_error();
        test_random();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
